rng_sequence_presenter: RTL and testbench
=========================================

Name: rng_sequence_presenter

Overview:
Transmit side of the memory game. On a Start pulse it generates SEQ_LEN pseudo-random 4-bit digits from an internal LFSR and shows them to both players one at a time. Each digit is shown for a timed window, followed by a blank gap. The player-entry and compare logic reads the captured sequence on SeqOut once Done pulses.

Parameters:
SEQ_LEN, 4, digits per round (1..8)
SHOW_CYCLES, 8, cycles each digit is displayed (>=1)
GAP_CYCLES, 2, blank cycles after each digit (>=1)
SEED, 8'hA5, LFSR reset value; 8'h00 is replaced by 8'h01

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous reset, active-high
Start  in  1  begin a round; sampled in IDLE only
AcsRNG  in  1  hold: while high, show/gap timers freeze and outputs hold
RNGDigit  out  4  digit being shown; 0 when DigitValid=0
DigitValid  out  1  high while a digit is on display
DigitIdx  out  3  index of the current or last digit (0..SEQ_LEN-1)
SegoutRNG  out  7  active-low 7-segment hex of RNGDigit, gfedcba order; 7'h7F (blank) when DigitValid=0
SeqOut  out  4*SEQ_LEN  captured digits, digit i in bits [4i+3:4i]
Busy  out  1  high in SHOW and GAP
Done  out  1  one-cycle pulse when the round completes
RoundNum  out  4  completed-round count

Behaviour:
- Reset (async, Rst=1): state IDLE; LFSR=SEED; timer, DigitIdx, RNGDigit, DigitValid, Busy, Done, RoundNum = 0; SeqOut=0; SegoutRNG=7'h7F.
- LFSR: 8-bit Fibonacci, shift left, new bit0 = b7^b5^b4^b3.
  - Advances only on digit capture, never free-running.
  - State persists across rounds; only reset reloads SEED.
- Capture: digit = LFSR[3:0]. It is written into SeqOut slot DigitIdx and RNGDigit on the same edge, and the LFSR advances on that edge.
- IDLE:
  - Start=1 at edge k: SeqOut cleared, DigitIdx=0, digit 0 captured, state SHOW.
  - From cycle k+1: DigitValid=1, Busy=1.
  - AcsRNG does not block Start.
- SHOW: timer counts SHOW_CYCLES cycles. Then go to GAP: DigitValid=0, RNGDigit=0.
- GAP: timer counts GAP_CYCLES cycles. Then:
  - if DigitIdx<SEQ_LEN-1: DigitIdx+1, capture next digit, go to SHOW;
  - else go to DONE.
- DONE: Done=1 and Busy=0 for exactly one cycle; RoundNum+1 (wraps 15->0); go to IDLE.
- Latency: Start at edge k gives Done high during cycle k+1+SEQ_LEN*(SHOW_CYCLES+GAP_CYCLES), absent hold.
- Hold: AcsRNG=1 in SHOW/GAP freezes the timer. State and all outputs are unchanged, and each held cycle extends latency by 1. AcsRNG is ignored in IDLE/DONE.
- Start while Busy or in DONE: ignored, no restart, no LFSR advance.
- Start held high: one round per IDLE entry; a new round begins on the cycle after DONE.
- SeqOut holds its value after Done until the next Start.
- Reset mid-round: immediate return to reset values. The partial sequence is lost and RoundNum is not incremented.

Test Plan:
1. Reset, then Start pulse at edge k (default parameters) -> RNGDigit 5,A,5,A, each with DigitValid for 8 cycles and a 2-cycle blank; SegoutRNG 7'h12 for 5, 7'h08 for A, 7'h7F in gaps; Done at k+41; SeqOut=16'hA5A5; RoundNum=1.
2. Second Start after test 1 -> digits begin 4, 9 (LFSR continues from 8'h54, not reseeded); RoundNum=2 at Done.
3. AcsRNG high for 5 cycles during digit 1 SHOW -> digit 1 is displayed 13 cycles; Done at k+46; digits unchanged.
4. Start pulses during SHOW and GAP, plus Start held high through DONE -> no restart; exactly one extra round starts the cycle after DONE; LFSR advances only 4 times per round.
5. Rst asserted mid-round asynchronously (not on a clock edge) -> outputs go to reset values before the next edge; the next round replays 5,A,5,A; RoundNum=0 until its Done.
6. Run 16 rounds -> RoundNum wraps 15->0; Done is exactly one cycle each round.

Source files
------------

// File: rtl/rng_sequence_presenter.sv
// Memory-game transmit side: on Start, captures SEQ_LEN pseudo-random hex digits
// from an LFSR and presents each one for a timed show window, then a blank gap.
// The captured round is left on SeqOut for the player-entry/compare logic.
module rng_sequence_presenter #(
    parameter int unsigned SEQ_LEN     = 4,
    parameter int unsigned SHOW_CYCLES = 8,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic                 AcsRNG,
    output logic [3:0]           RNGDigit,
    output logic                 DigitValid,
    output logic [2:0]           DigitIdx,
    output logic [6:0]           SegoutRNG,
    output logic [4*SEQ_LEN-1:0] SeqOut,
    output logic                 Busy,
    output logic                 Done,
    output logic [3:0]           RoundNum
);

    localparam int unsigned MAX_CYCLES = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned TIMER_W    = $clog2(MAX_CYCLES + 1);

    localparam logic [TIMER_W-1:0] SHOW_LAST = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [2:0]         LAST_IDX  = 3'(SEQ_LEN - 1);
    // An all-zero seed would lock the LFSR up, so it is nudged to 1.
    localparam logic [7:0]         SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHOW = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]           stateQ, stateD;
    logic [TIMER_W-1:0]   timerQ, timerD;
    logic [2:0]           idxQ, idxD;
    logic [7:0]           lfsrQ, lfsrNext;
    logic [3:0]           digitQ, digitD;
    logic [4*SEQ_LEN-1:0] seqQ, seqD;
    logic [3:0]           roundQ, roundD;
    logic                 capture;

    assign lfsrNext = {lfsrQ[6:0], lfsrQ[7] ^ lfsrQ[5] ^ lfsrQ[4] ^ lfsrQ[3]};

    // Sequencer: next state, timer, digit index, captured digits and round count.
    always_comb begin
        stateD  = stateQ;
        timerD  = timerQ;
        idxD    = idxQ;
        digitD  = digitQ;
        roundD  = roundQ;
        seqD    = seqQ;
        capture = 1'b0;

        case (stateQ)
            IDLE: begin
                if (Start) begin
                    seqD    = '0;
                    idxD    = 3'd0;
                    timerD  = '0;
                    capture = 1'b1;
                    stateD  = SHOW;
                end
            end
            SHOW: begin
                // AcsRNG freezes the whole presentation, not just the timer.
                if (!AcsRNG) begin
                    if (timerQ == SHOW_LAST) begin
                        timerD = '0;
                        digitD = 4'd0;
                        stateD = GAP;
                    end else begin
                        timerD = timerQ + 1'b1;
                    end
                end
            end
            GAP: begin
                if (!AcsRNG) begin
                    if (timerQ == GAP_LAST) begin
                        timerD = '0;
                        if (idxQ == LAST_IDX) begin
                            roundD = roundQ + 4'd1;
                            stateD = DONE;
                        end else begin
                            idxD    = idxQ + 3'd1;
                            capture = 1'b1;
                            stateD  = SHOW;
                        end
                    end else begin
                        timerD = timerQ + 1'b1;
                    end
                end
            end
            DONE: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase

        if (capture) begin
            digitD = lfsrQ[3:0];
            for (int unsigned i = 0; i < SEQ_LEN; i++) begin
                if (idxD == 3'(i)) begin
                    seqD[4*i +: 4] = lfsrQ[3:0];
                end
            end
        end
    end

    // State registers; the LFSR only steps when a digit is captured.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stateQ <= IDLE;
            timerQ <= '0;
            idxQ   <= 3'd0;
            lfsrQ  <= SEED_EFF;
            digitQ <= 4'd0;
            seqQ   <= '0;
            roundQ <= 4'd0;
        end else begin
            stateQ <= stateD;
            timerQ <= timerD;
            idxQ   <= idxD;
            digitQ <= digitD;
            seqQ   <= seqD;
            roundQ <= roundD;
            if (capture) begin
                lfsrQ <= lfsrNext;
            end
        end
    end

    // Status outputs decoded straight from state so reset clears them at once.
    always_comb begin
        DigitValid = (stateQ == SHOW);
        Busy       = (stateQ == SHOW) || (stateQ == GAP);
        Done       = (stateQ == DONE);
        RNGDigit   = digitQ;
        DigitIdx   = idxQ;
        SeqOut     = seqQ;
        RoundNum   = roundQ;
    end

    // Active-low gfedcba hex decode; blank whenever nothing is on display.
    always_comb begin
        SegoutRNG = 7'h7F;
        if (stateQ == SHOW) begin
            case (digitQ)
                4'h0: SegoutRNG = 7'h40;
                4'h1: SegoutRNG = 7'h79;
                4'h2: SegoutRNG = 7'h24;
                4'h3: SegoutRNG = 7'h30;
                4'h4: SegoutRNG = 7'h19;
                4'h5: SegoutRNG = 7'h12;
                4'h6: SegoutRNG = 7'h02;
                4'h7: SegoutRNG = 7'h78;
                4'h8: SegoutRNG = 7'h00;
                4'h9: SegoutRNG = 7'h10;
                4'hA: SegoutRNG = 7'h08;
                4'hB: SegoutRNG = 7'h03;
                4'hC: SegoutRNG = 7'h46;
                4'hD: SegoutRNG = 7'h21;
                4'hE: SegoutRNG = 7'h06;
                4'hF: SegoutRNG = 7'h0E;
                default: SegoutRNG = 7'h7F;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_sequence_presenter.sv
// Self-checking bench for rng_sequence_presenter with default parameters.
// Expected behaviour comes from a round-level model: a list of digits drawn
// from the LFSR rule, and a position t in the unheld round timeline.
module tb_rng_sequence_presenter;

    localparam int SEQ_LEN     = 4;
    localparam int SHOW_CYCLES = 8;
    localparam int GAP_CYCLES  = 2;
    localparam int PER         = SHOW_CYCLES + GAP_CYCLES;
    localparam int ROUND_T     = SEQ_LEN * PER;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic        AcsRNG;
    logic [3:0]  RNGDigit;
    logic        DigitValid;
    logic [2:0]  DigitIdx;
    logic [6:0]  SegoutRNG;
    logic [15:0] SeqOut;
    logic        Busy;
    logic        Done;
    logic [3:0]  RoundNum;

    int compared   = 0;
    int mismatched = 0;

    // Model state carried between rounds.
    logic [7:0]  mLfsr;
    logic [3:0]  mRound;
    logic [15:0] mSeq;
    logic [2:0]  mIdx;

    logic [6:0] segTbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    rng_sequence_presenter #(
        .SEQ_LEN     (SEQ_LEN),
        .SHOW_CYCLES (SHOW_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .SEED        (8'hA5)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .AcsRNG     (AcsRNG),
        .RNGDigit   (RNGDigit),
        .DigitValid (DigitValid),
        .DigitIdx   (DigitIdx),
        .SegoutRNG  (SegoutRNG),
        .SeqOut     (SeqOut),
        .Busy       (Busy),
        .Done       (Done),
        .RoundNum   (RoundNum)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] lfsrStep(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic resetModel();
        mLfsr  = 8'hA5;
        mRound = 4'd0;
        mSeq   = 16'h0;
        mIdx   = 3'd0;
    endtask

    task automatic checkReset();
        check("rst_RNGDigit", RNGDigit, 0);
        check("rst_DigitValid", DigitValid, 0);
        check("rst_DigitIdx", DigitIdx, 0);
        check("rst_SegoutRNG", SegoutRNG, 7'h7F);
        check("rst_SeqOut", SeqOut, 0);
        check("rst_Busy", Busy, 0);
        check("rst_Done", Done, 0);
        check("rst_RoundNum", RoundNum, 0);
    endtask

    task automatic checkIdle();
        check("idle_DigitValid", DigitValid, 0);
        check("idle_RNGDigit", RNGDigit, 0);
        check("idle_SegoutRNG", SegoutRNG, 7'h7F);
        check("idle_DigitIdx", DigitIdx, mIdx);
        check("idle_Busy", Busy, 0);
        check("idle_Done", Done, 0);
        check("idle_SeqOut", SeqOut, mSeq);
        check("idle_RoundNum", RoundNum, mRound);
    endtask

    // Called at a negedge with the DUT idle. Start is raised for the coming edge,
    // then every cycle is checked until the Done cycle, where the task returns.
    // holdAt/holdLen: hold AcsRNG for holdLen cycles once the timeline reaches holdAt.
    task automatic playRound(input int holdAt, input int holdLen, input bit randHold,
                             input bit noise, input bit keepStart);
        logic [3:0]  d [SEQ_LEN];
        logic [15:0] fullSeq;
        logic [15:0] partSeq;
        logic        valid;
        int          t, cyc, holds, left, i, firstDone;

        fullSeq = 16'h0;
        for (int j = 0; j < SEQ_LEN; j++) begin
            d[j] = mLfsr[3:0];
            fullSeq[4*j +: 4] = mLfsr[3:0];
            mLfsr = lfsrStep(mLfsr);
        end

        Start  = 1'b1;
        AcsRNG = 1'($urandom_range(0, 1));
        t = 0; cyc = 0; holds = 0; left = holdLen; firstDone = 0;

        forever begin
            @(negedge Clk);
            cyc++;
            if (Done === 1'b1 && firstDone == 0) firstDone = cyc;
            if (cyc > ROUND_T + 200) begin
                compared++;
                mismatched++;
                $error("FAIL round_timeout: observed cycle %0d expected done by %0d",
                       cyc, ROUND_T + 200);
                Start  = 1'b0;
                AcsRNG = 1'b0;
                return;
            end

            i     = (t < ROUND_T) ? (t / PER) : (SEQ_LEN - 1);
            valid = (t < ROUND_T) && ((t % PER) < SHOW_CYCLES);
            partSeq = 16'h0;
            for (int j = 0; j < SEQ_LEN; j++) begin
                if (j <= i) partSeq[4*j +: 4] = d[j];
            end

            check("DigitValid", DigitValid, valid);
            check("RNGDigit", RNGDigit, valid ? d[i] : 4'd0);
            check("SegoutRNG", SegoutRNG, valid ? segTbl[d[i]] : 7'h7F);
            check("DigitIdx", DigitIdx, i);
            check("Busy", Busy, t < ROUND_T);
            check("Done", Done, t == ROUND_T);
            check("SeqOut", SeqOut, partSeq);
            check("RoundNum", RoundNum, (t == ROUND_T) ? 4'(mRound + 4'd1) : mRound);

            if (t == ROUND_T) begin
                check("DoneLatency", firstDone, 1 + ROUND_T + holds);
                mRound = mRound + 4'd1;
                mSeq   = fullSeq;
                mIdx   = 3'(SEQ_LEN - 1);
                Start  = keepStart;
                AcsRNG = 1'($urandom_range(0, 1));
                return;
            end

            Start = keepStart ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            if (left > 0 && t == holdAt) begin
                AcsRNG = 1'b1;
                left--;
            end else begin
                AcsRNG = randHold ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            if (AcsRNG) holds++;
            else t++;
        end
    endtask

    initial begin
        Rst    = 1'b1;
        Start  = 1'b0;
        AcsRNG = 1'b0;
        resetModel();
        #12;
        checkReset();
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        checkIdle();

        // First round after reset: 5,A,5,A.
        playRound(-1, 0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        checkIdle();
        check("round1_SeqOut", SeqOut, 16'hA5A5);

        // Second round continues the LFSR: 4,9,...
        playRound(-1, 0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        checkIdle();
        check("round2_SeqOut_low", SeqOut[7:0], 8'h94);

        // Five held cycles during digit 1 show.
        playRound(PER + 2, 5, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        checkIdle();

        // Start noise during show/gap, then Start held through DONE.
        playRound(-1, 0, 1'b0, 1'b1, 1'b1);
        @(negedge Clk);
        checkIdle();
        playRound(-1, 0, 1'b0, 1'b1, 1'b0);
        @(negedge Clk);
        checkIdle();

        // Idle with AcsRNG toggling and no Start: nothing moves.
        for (int n = 0; n < 3; n++) begin
            AcsRNG = 1'($urandom_range(0, 1));
            @(negedge Clk);
            checkIdle();
        end

        // Asynchronous reset in the middle of a round.
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (14) @(negedge Clk);
        #2 Rst = 1'b1;
        #1 checkReset();
        @(negedge Clk);
        Rst = 1'b0;
        resetModel();
        @(negedge Clk);
        checkIdle();
        playRound(-1, 0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        checkIdle();
        check("replay_SeqOut", SeqOut, 16'hA5A5);

        // Sixteen randomized rounds; RoundNum wraps 15->0 along the way.
        for (int r = 0; r < 16; r++) begin
            playRound(int'($urandom_range(0, ROUND_T - 1)), int'($urandom_range(0, 3)),
                      1'b1, 1'b1, 1'($urandom_range(0, 1)));
            @(negedge Clk);
            checkIdle();
        end
        check("final_RoundNum", RoundNum, 4'd1);

        Start  = 1'b0;
        AcsRNG = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
